rom_stream_reader: RTL and testbench
====================================

# rom_stream_reader

Read-side master for the 16x16 synchronous ROM (`ROM_design`). Given a start address and a word count, it drives the ROM address port, tracks the ROM's one-cycle read latency, and streams the returned words out on a valid/ready interface. A two-entry skid FIFO absorbs in-flight words under backpressure. It sits between `ROM_design` and any consumer of table data, such as a microcode or coefficient fetch.

## Interface
- `AW`, default 4: ROM address width.
- `DW`, default 16: ROM data width.
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `start` in 1: request pulse, sampled only in IDLE.
- `start_addr` in AW: first ROM address to read.
- `count` in AW+1: number of words, 1..2^AW. A value of 0 means `start` is ignored.
- `rom_adr` out AW: drives `ROM_design.ADR`.
- `rom_d` in DW: from `ROM_design.D`. Registered: it reflects M[ADR] one edge after ADR.
- `out_data` out DW: streamed word.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: consumer accepts. A transfer occurs when valid and ready are both high at the edge.
- `busy` out 1: a transfer is in progress.
- `done` out 1: one-cycle pulse after the last word is accepted.

## Operation
- Reset values: `rom_adr`=0, `out_data`=0, `out_valid`=0, `busy`=0, `done`=0. FIFO empty, in-flight flag clear, state IDLE.
- States:
  - IDLE -> RUN on `start` && `count`!=0. This latches `remaining`=`count` and `rom_adr`=`start_addr`, and sets `busy`.
  - RUN -> DRAIN when the final address is issued (`remaining` hits 0).
  - DRAIN -> IDLE when the FIFO is empty, nothing is in flight, and the last transfer occurs. `done` pulses on that edge's following cycle.
- Issue rule:
  - A read is issued on an edge when `remaining`>0 and (occupancy + inflight − pop) < 2.
  - pop = `out_valid` && `out_ready` on the same edge.
  - On issue: the word at the current `rom_adr` becomes in flight; `rom_adr` increments; `remaining` decrements.
- Capture: one edge after an issue, `rom_d` is written into the FIFO. The in-flight flag clears unless a new issue happens on the same edge.
- Address wrap: `rom_adr` increments modulo 2^AW (15 -> 0). `count`=16 reads every location exactly once.
- Between issues `rom_adr` holds its value. Repeated ROM reads are harmless and are never captured.
- `start` while busy is ignored, with no effect on the current transfer.
- `out_data`/`out_valid` are driven from the FIFO head and are stable while `out_valid` && !`out_ready`. No word is dropped or duplicated.
- Simultaneous FIFO push and pop at occupancy 1 or 2: occupancy is unchanged and order is preserved.
- `RST` mid-operation: everything returns immediately to reset values, `out_valid` drops asynchronously, and in-flight data is discarded.

## Timing
- `start` sampled at edge E0:
  - `rom_adr`=`start_addr` after E0.
  - `rom_d` valid after E1.
  - FIFO write at E2.
  - `out_valid` high after E2.
- First-word latency: 2 cycles from the `start` edge.
- Throughput with `out_ready` held high: 1 word per cycle. N words complete in N+2 cycles plus the `done` cycle.
- Under backpressure at most 2 words are stored. Issuing stalls within one cycle and resumes on the edge of the first pop.
- `busy` falls on the same edge that `done` rises.

## Structure
- Shared package `rom_pkg`:
  - `ROM_AW`=4, `ROM_DW`=16.
  - `rd_state_t` enum {IDLE, RUN, DRAIN}.
- Sub-module `rom_skid_fifo`:
  - 2-entry, DW wide.
  - Ports: push, push_data, pop, head, valid, occupancy[1:0].
- The top level holds the FSM, address/remaining counters, and the in-flight flag.

## Test plan
- Bench ROM preload: M[0]=0x0103, M[1]=0x5200, M[14]=0x4444, M[15]=0x5555.
- Basic read: start_addr=0, count=2, `out_ready`=1 -> 0x0103 then 0x5200 on consecutive cycles, first word 2 cycles after `start`, then `done` pulses once and `busy`=0.
- Wrap: start_addr=14, count=4, `out_ready`=1 -> 0x4444, 0x5555, 0x0103, 0x5200 in order.
- Backpressure: count=16, `out_ready` low for 5 cycles mid-stream -> `out_data` held stable, all 16 words delivered exactly once in address order, and FIFO occupancy never exceeds 2.
- Ignored requests: `count`=0 with `start` -> `busy` stays 0 and no `done`. A `start` pulse during RUN with start_addr=8 -> the current stream is unaffected.
- Reset mid-transfer: assert `RST` after 3 words of a 10-word read -> `out_valid`/`busy` go to 0 immediately. A new start_addr=1, count=1 then returns 0x5200 with normal latency.

Source files
------------

// File: rtl/rom_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rom_pkg
// Purpose  : Shared ROM geometry and reader state encoding.
// Revision : 1.0
// ============================================================================
package rom_pkg;

    localparam int ROM_AW = 4;
    localparam int ROM_DW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

endpackage : rom_pkg
`default_nettype wire

// File: rtl/rom_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : rom_stream_reader_if
// Purpose  : Request, ROM-side and stream-side signals of the ROM reader.
// Revision : 1.0
// ============================================================================
interface rom_stream_reader_if #(
    parameter int AW = rom_pkg::ROM_AW,
    parameter int DW = rom_pkg::ROM_DW
);
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   count;
    logic [AW-1:0] rom_adr;
    logic [DW-1:0] rom_d;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    modport master (
        input  start, start_addr, count, rom_d, out_ready,
        output rom_adr, out_data, out_valid, busy, done
    );

    modport slave (
        output start, start_addr, count, rom_d, out_ready,
        input  rom_adr, out_data, out_valid, busy, done
    );
endinterface : rom_stream_reader_if
`default_nettype wire

// File: rtl/rom_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rom_skid_fifo
// Purpose  : Two-entry skid buffer holding ROM words awaiting the consumer.
// Revision : 1.0
// ============================================================================
module rom_skid_fifo #(
    parameter int DW = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_push,
    input  wire logic [DW-1:0] i_push_data,
    input  wire logic          i_pop,
    output logic      [DW-1:0] o_head,
    output logic               o_valid,
    output logic      [1:0]    o_occupancy
);
    logic [DW-1:0] r_mem [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_occ;
    logic          w_pop_ok;
    logic          w_push_ok;

    assign w_pop_ok  = i_pop && (r_occ != 2'd0);
    // A push into a full buffer is only legal when the head leaves on the same edge.
    assign w_push_ok = i_push && ((r_occ != 2'd2) || w_pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_head      = r_mem[r_rd_ptr];
    assign o_valid     = (r_occ != 2'd0);
    assign o_occupancy = r_occ;
endmodule : rom_skid_fifo
`default_nettype wire

// File: rtl/rom_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : rom_stream_reader
// Purpose  : Streams a run of words from a 1-cycle-latency synchronous ROM.
// Revision : 1.0
// ============================================================================
module rom_stream_reader
    import rom_pkg::*;
#(
    parameter int AW = ROM_AW,
    parameter int DW = ROM_DW
) (
    input  wire logic            clk,
    input  wire logic            rst,
    rom_stream_reader_if.master  bus
);
    rd_state_t     r_state;
    logic [AW:0]   r_remaining;
    logic [AW-1:0] r_adr;
    logic          r_inflight;
    logic          r_busy;
    logic          r_done;

    logic [DW-1:0] w_head;
    logic          w_fifo_valid;
    logic [1:0]    w_occ;
    logic          w_pop;
    logic [2:0]    w_slots;
    logic          w_issue;
    logic          w_last_pop;

    assign w_pop = w_fifo_valid && bus.out_ready;

    // Words held plus word in flight, after this edge's pop, must leave room for one more.
    assign w_slots    = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue    = (r_state == RUN) && (r_remaining != '0) && (w_slots < 3'd2);
    assign w_last_pop = (r_state == DRAIN) && !r_inflight && (w_occ == 2'd1) && w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_adr       <= '0;
            r_inflight  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_adr       <= r_adr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (bus.start && (bus.count != '0)) begin
                        r_state     <= RUN;
                        r_remaining <= bus.count;
                        r_adr       <= bus.start_addr;
                        r_busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_issue && (r_remaining == {{AW{1'b0}}, 1'b1})) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_last_pop) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    rom_skid_fifo #(.DW(DW)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_push_data (bus.rom_d),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_valid     (w_fifo_valid),
        .o_occupancy (w_occ)
    );

    assign bus.rom_adr   = r_adr;
    assign bus.out_data  = w_head;
    assign bus.out_valid = w_fifo_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule : rom_stream_reader
`default_nettype wire

// File: tb/tb_rom_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_stream_reader
// Purpose  : Scoreboard bench for rom_stream_reader with a behavioural ROM.
// Revision : 1.0
// ============================================================================
module tb_rom_stream_reader;
    logic clk = 1'b0;
    logic rst;

    rom_stream_reader_if #(.AW(4), .DW(16)) bus ();

    rom_stream_reader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [16];
    always @(posedge clk) bus.rom_d <= mem[bus.rom_adr];

    logic [15:0] exp_q [$];
    int n_vec  = 0;
    int n_err  = 0;
    int n_done = 0;
    int n_pop  = 0;
    bit rdy_rand = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every transfer and checks hold-under-stall.
    initial begin : monitor
        bit          prev_stall;
        logic [15:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
                    chk("hold_data", {16'd0, bus.out_data}, {16'd0, prev_data});
                end
                if (bus.out_valid) begin
                    chk("occupancy_le2", {31'd0, (dut.w_occ <= 2'd2)}, 32'd1);
                end
                if (bus.out_valid && bus.out_ready) begin
                    n_pop++;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_word: got %h expected none at %0t", bus.out_data, $time);
                    end else begin
                        chk("stream_word", {16'd0, bus.out_data}, {16'd0, exp_q.pop_front()});
                    end
                end
                if (bus.done) n_done++;
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
            end
        end
    end

    initial begin : ready_gen
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    // Reference model: a request of n words from a yields M[(a+i) mod 16].
    task automatic start_req(input int addr, input int cnt);
        @(posedge clk);
        #1;
        bus.start      = 1'b1;
        bus.start_addr = 4'(addr);
        bus.count      = 5'(cnt);
        for (int i = 0; i < cnt; i++) exp_q.push_back(mem[(addr + i) % 16]);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic start_raw(input int addr, input int cnt);
        @(posedge clk);
        #1;
        bus.start      = 1'b1;
        bus.start_addr = 4'(addr);
        bus.count      = 5'(cnt);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic start_lat(input int addr, input int cnt);
        start_req(addr, cnt);
        chk("adr_after_start", {28'd0, bus.rom_adr}, 32'(addr));
        @(negedge clk);
        chk("valid_e0", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        chk("valid_e1", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        chk("valid_e2", {31'd0, bus.out_valid}, 32'd1);
        chk("first_word", {16'd0, bus.out_data}, {16'd0, mem[addr % 16]});
    endtask

    task automatic wait_done(input int d0, input int budget);
        int t = 0;
        while (n_done == d0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("done_once", 32'(n_done - d0), 32'd1);
        chk("busy_idle", {31'd0, bus.busy}, 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : main
        int d0;
        int p0;
        int t;
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        mem[0]  = 16'h0103;
        mem[1]  = 16'h5200;
        mem[14] = 16'h4444;
        mem[15] = 16'h5555;
        rst = 1'b1;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.count      = '0;
        bus.out_ready  = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rom_adr", {28'd0, bus.rom_adr}, 32'd0);
        chk("rst_out_data", {16'd0, bus.out_data}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        rst = 1'b0;

        d0 = n_done;
        start_lat(0, 2);
        wait_done(d0, 40);

        d0 = n_done;
        start_req(14, 4);
        wait_done(d0, 40);

        d0 = n_done;
        start_req(0, 16);
        repeat (6) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_done(d0, 80);

        d0 = n_done;
        start_raw(3, 0);
        repeat (6) @(negedge clk);
        chk("cnt0_busy", {31'd0, bus.busy}, 32'd0);
        chk("cnt0_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("cnt0_no_done", 32'(n_done - d0), 32'd0);

        d0 = n_done;
        start_req(0, 16);
        repeat (3) @(posedge clk);
        start_raw(8, 5);
        wait_done(d0, 80);

        p0 = n_pop;
        start_req(0, 10);
        t = 0;
        while ((n_pop - p0) < 3 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("pre_reset_words", {31'd0, ((n_pop - p0) >= 3)}, 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        d0 = n_done;
        start_lat(1, 1);
        wait_done(d0, 40);

        rdy_rand = 1'b1;
        for (int k = 0; k < 8; k++) begin
            d0 = n_done;
            start_req($urandom_range(0, 15), $urandom_range(1, 16));
            wait_done(d0, 400);
        end
        rdy_rand = 1'b0;
        #2;
        bus.out_ready = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule : tb_rom_stream_reader
`default_nettype wire
